// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives instruction memory and fills the
// IF/ID pipeline register. Handles stall, flush, branch and jump redirects.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] Instruction,
  output logic [31:0] PCAddress,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic [31:0] FetchCount
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        vld_q, vld_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        squash;

  // Word-align a redirect target; the low two bits are never meaningful.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    word_align = addr & ~32'h0000_0003;
  endfunction

  assign pc_plus4 = pc_q + 32'd4;
  assign redirect = Jump | BranchTaken;
  assign squash   = Flush | redirect;

  always_comb begin
    pc_d = pc_plus4;
    if (Jump) begin
      pc_d = word_align(JumpTarget);
    end else if (BranchTaken) begin
      pc_d = word_align(BranchTarget);
    end else if (Stall) begin
      pc_d = pc_q;
    end
  end

  always_comb begin
    instr_d = Instruction;
    pcp4_d  = pc_plus4;
    vld_d   = 1'b1;
    if (squash) begin
      instr_d = NOP_WORD;
      pcp4_d  = 32'd0;
      vld_d   = 1'b0;
    end else if (Stall) begin
      instr_d = instr_q;
      pcp4_d  = pcp4_q;
      vld_d   = vld_q;
    end
  end

  // Count only edges that actually load a live instruction, not held ones.
  always_comb begin
    cnt_d = cnt_q;
    if (!squash && !Stall) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // PC and IF/ID pipeline register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pcp4_q  <= 32'd0;
      vld_q   <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PCAddress        = pc_q;
  assign IFID_Instruction = instr_q;
  assign IFID_PCPlus4     = pcp4_q;
  assign IFID_Valid       = vld_q;
  assign FetchCount       = cnt_q;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front end of the pipelined MIPS datapath.
- Owns the program counter and drives the byte address into the combinational 128-word instruction memory.
- Captures the returned 32-bit instruction, together with PC+4, into the IF/ID pipeline register for the decode stage.
- Supports stall, flush, branch redirect and jump redirect; keeps a retired-fetch counter for debug.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_WORD, 32'h00000000, instruction word inserted into IF/ID on flush and reset (sll $0,$0,0).

Ports:
- Clk  input  1  system clock, all state updates on rising edge.
- Rst  input  1  asynchronous, active-low reset.
- Stall  input  1  hazard unit request to hold PC and IF/ID.
- Flush  input  1  squash the instruction entering IF/ID.
- BranchTaken  input  1  branch resolved taken this cycle.
- BranchTarget  input  32  branch destination byte address.
- Jump  input  1  jump resolved this cycle.
- JumpTarget  input  32  jump destination byte address.
- Instruction  input  32  word returned by instruction memory for PCAddress (same cycle, combinational).
- PCAddress  output  32  current PC, drives instruction memory Address.
- IFID_Instruction  output  32  registered instruction to decode.
- IFID_PCPlus4  output  32  registered PC+4 of that instruction.
- IFID_Valid  output  1  IF/ID holds a real (non-squashed) instruction.
- FetchCount  output  32  number of valid instructions latched into IF/ID since reset.

Behaviour:
- Reset (Rst=0, asynchronous, any time including mid-stall or mid-redirect):
  - PCAddress=RESET_PC, IFID_Instruction=NOP_WORD, IFID_PCPlus4=0, IFID_Valid=0, FetchCount=0.
  - First edge after Rst deasserts fetches RESET_PC normally.
- PC arithmetic:
  - PCPlus4 = PCAddress + 4, 32-bit, wraps modulo 2^32 (32'hFFFFFFFC -> 0).
  - Targets are used with bits [1:0] forced to 2'b00.
- Next-PC priority, highest first:
  - Jump -> JumpTarget.
  - BranchTaken -> BranchTarget.
  - Stall -> hold PCAddress.
  - otherwise -> PCPlus4.
  - Redirects override Stall. Jump and BranchTaken together: Jump wins.
- IF/ID register priority, highest first:
  - Flush or Jump or BranchTaken -> load NOP_WORD, IFID_PCPlus4=0, IFID_Valid=0. Flush overrides Stall.
  - Stall -> hold all IF/ID outputs.
  - otherwise -> load Instruction, PCPlus4, IFID_Valid=1.
- FetchCount increments by 1 on every edge where IF/ID loads with IFID_Valid=1; wraps modulo 2^32; holds otherwise.
- Latency:
  - Instruction at PC p appears on IFID_Instruction one edge after PCAddress=p, provided no stall, flush or redirect on that edge.
  - A redirect asserted in cycle n sets PCAddress=target after edge n; the target's instruction reaches IF/ID after edge n+1.
- No combinational path from Stall, Flush or redirect inputs to PCAddress; PCAddress is a pure register output.

Test Plan:
- Reset release, no control inputs, memory returning index-dependent words:
  - PCAddress steps 0,4,8,... each edge.
  - IFID_Instruction lags by one edge with IFID_PCPlus4=PC+4.
  - IFID_Valid=1 from the first edge; FetchCount=5 after 5 edges.
- Stall held 3 cycles at PCAddress=0x10:
  - PCAddress stays 0x10 and IF/ID holds for 3 edges; FetchCount frozen.
  - On release, IF/ID loads word@0x10 and PCAddress becomes 0x14.
- BranchTaken=1 with BranchTarget=0x43 while Stall=1 at PC=0x08:
  - Next PCAddress=0x40, IFID_Valid=0, IF/ID=NOP_WORD.
  - Following edge latches word@0x40 with IFID_PCPlus4=0x44.
- Jump=1 (JumpTarget=0x60) and BranchTaken=1 (BranchTarget=0x20) in the same cycle:
  - PCAddress=0x60 and IF/ID squashed.
- Flush=1 and Stall=1 together at PC=0x0C:
  - PCAddress holds 0x0C, IF/ID=NOP_WORD, IFID_Valid=0, FetchCount unchanged.
- Boundary and reset:
  - PCAddress=0xFFFFFFFC with no controls -> next PCAddress=0x0 and IFID_PCPlus4=0x0.
  - Rst pulsed low between edges mid-run -> all outputs return to reset values immediately, without waiting for Clk.
